// File: rtl/triangle_sides_cordic.sv
// -----------------------------------------------------------------------------
// triangle_sides_cordic
//
// Iterative rotation-mode CORDIC that resolves a right triangle from an integer
// angle (degrees) and a hypotenuse:
//   a = hyp * cos(angle), b = hyp * sin(angle), c = hyp.
// One micro-rotation per clock; valid/ready handshake on both sides.
//
// Parameters
//   WIDTH  signed width of angle, hypotenuse, a, b, c
//   ITER   number of CORDIC micro-rotations (8..24)
//   FRAC   fractional bits of the X/Y/Z datapath (Z holds degrees)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset
//   in_valid    request valid (angle/hypotenuse)
//   in_ready    block is idle and accepts a request
//   angle       signed degrees, legal -180..180
//   hypotenuse  signed, legal 0..2^(WIDTH-2)-1
//   out_valid   a/b/c/out_err valid, held until out_ready
//   out_ready   consumer accepts the result
//   a, b, c     signed results
//   out_err     request was outside the legal range (a=b=c=0)
//
// Build option
//   TRI_SIDES_ROUND_EN  when defined, a/b are rounded half-up to nearest;
//                       otherwise they are floored. Latency is unchanged.
// -----------------------------------------------------------------------------
module triangle_sides_cordic #(
    parameter int WIDTH = 32,
    parameter int ITER  = 16,
    parameter int FRAC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] angle,
    input  logic signed [WIDTH-1:0] hypotenuse,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] a,
    output logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] c,
    output logic                    out_err
);

    localparam int XW = WIDTH + FRAC + 2;  // X/Y: headroom for CORDIC growth
    localparam int ZW = 9 + FRAC;          // Z: +-256 degrees in Q.FRAC
    localparam int CW = $clog2(ITER);

    // atan(2^-i) in degrees, packed as ITER entries of ZW bits in Q.FRAC.
    function automatic logic [ITER*ZW-1:0] atan_table();
        logic [ITER*ZW-1:0] tab;
        real                deg;
        tab = '0;
        for (int i = 0; i < ITER; i++) begin
            case (i)
                0:       deg = 45.0;
                1:       deg = 26.565051177077990;
                2:       deg = 14.036243467926479;
                3:       deg = 7.125016348901798;
                4:       deg = 3.576334374997352;
                5:       deg = 1.789910608246069;
                6:       deg = 0.895173710211074;
                7:       deg = 0.447614170860553;
                8:       deg = 0.223810500368538;
                9:       deg = 0.111905677066207;
                10:      deg = 0.055952891893804;
                11:      deg = 0.027976452617004;
                12:      deg = 0.013988227142265;
                13:      deg = 0.006994113675353;
                14:      deg = 0.003497056850704;
                15:      deg = 0.001748528426980;
                16:      deg = 0.000874264213694;
                17:      deg = 0.000437132106872;
                18:      deg = 0.000218566053439;
                19:      deg = 0.000109283026720;
                20:      deg = 0.000054641513360;
                21:      deg = 0.000027320756680;
                22:      deg = 0.000013660378340;
                23:      deg = 0.000006830189170;
                default: deg = 0.0;
            endcase
            tab[i*ZW +: ZW] = ZW'($rtoi(deg * (2.0 ** FRAC) + 0.5));
        end
        return tab;
    endfunction

    localparam logic [ITER*ZW-1:0]   ATAN_TAB = atan_table();
    // CORDIC gain compensation, pre-applied to x0 so no final multiply is needed.
    localparam logic signed [XW-1:0] K_X      = XW'($rtoi(0.6072529350 * (2.0 ** FRAC) + 0.5));
    localparam logic signed [WIDTH-1:0] HYP_MAX = {2'b00, {(WIDTH-2){1'b1}}};
    localparam logic [CW-1:0]        LAST     = CW'(ITER - 1);

`ifdef TRI_SIDES_ROUND_EN
    localparam logic signed [XW-1:0] BIAS = {{(XW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`else
    localparam logic signed [XW-1:0] BIAS = '0;
`endif

    typedef enum logic [1:0] {IDLE, PREP, ROTATE, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic signed [WIDTH-1:0] angle_r, hyp_r;
    logic                    err_r;
    logic signed [XW-1:0]    x, y;
    logic signed [ZW-1:0]    z;

    logic signed [XW-1:0]    x_sh, y_sh, hyp_k;
    logic signed [ZW-1:0]    atan_i;
    logic                    angle_ok, hyp_ok;

    assign x_sh     = x >>> cnt;
    assign y_sh     = y >>> cnt;
    assign atan_i   = ZW'(ATAN_TAB[cnt*ZW +: ZW]);
    assign hyp_k    = XW'(hyp_r) * K_X;
    assign angle_ok = (angle_r >= -180) && (angle_r <= 180);
    assign hyp_ok   = (hyp_r >= 0) && (hyp_r <= HYP_MAX);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values; blocking here would chain x into y
    // within one micro-rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            angle_r   <= '0;
            hyp_r     <= '0;
            err_r     <= 1'b0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        angle_r  <= angle;
                        hyp_r    <= hypotenuse;
                        err_r    <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= PREP;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                PREP: begin
                    cnt <= '0;
                    y   <= '0;
                    if (!(angle_ok && hyp_ok)) begin
                        err_r <= 1'b1;
                        state <= DONE;
                    end else begin
                        // Fold |angle|>90 into +-90 by rotating from -hyp.
                        if (angle_r > 90) begin
                            z <= ZW'(angle_r - 180) <<< FRAC;
                            x <= -hyp_k;
                        end else if (angle_r < -90) begin
                            z <= ZW'(angle_r + 180) <<< FRAC;
                            x <= -hyp_k;
                        end else begin
                            z <= ZW'(angle_r) <<< FRAC;
                            x <= hyp_k;
                        end
                        state <= ROTATE;
                    end
                end

                ROTATE: begin
                    if (z[ZW-1]) begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan_i;
                    end else begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan_i;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end

                DONE: begin
                    // First DONE cycle registers the result; afterwards hold
                    // it until the consumer takes it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_err   <= err_r;
                        if (err_r) begin
                            a <= '0;
                            b <= '0;
                            c <= '0;
                        end else begin
                            a <= WIDTH'((x + BIAS) >>> FRAC);
                            b <= WIDTH'((y + BIAS) >>> FRAC);
                            c <= hyp_r;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_sides_cordic.sv
// -----------------------------------------------------------------------------
// tb_triangle_sides_cordic
//
// Scoreboard bench: each request pushes its expected a/b/c/out_err and latency
// onto a queue; the result is popped and compared when the DUT presents it.
// a/b are accepted within +-1 LSB of the listed floor/round values.
// -----------------------------------------------------------------------------
module tb_triangle_sides_cordic;

    localparam int WIDTH = 32;
    localparam int ITER  = 16;
    localparam int FRAC  = 16;

`ifdef TRI_SIDES_ROUND_EN
    localparam int B50  = 23;
    localparam int B135 = 71;
    localparam int A150 = -43;
`else
    localparam int B50  = 22;
    localparam int B135 = 70;
    localparam int A150 = -44;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [WIDTH-1:0] angle = '0;
    logic signed [WIDTH-1:0] hypotenuse = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [WIDTH-1:0] a, b, c;
    logic                    out_err;

    triangle_sides_cordic #(.WIDTH(WIDTH), .ITER(ITER), .FRAC(FRAC)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .angle      (angle),
        .hypotenuse (hypotenuse),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a          (a),
        .b          (b),
        .c          (c),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ang;
        int hyp;
        int a;
        int b;
        int c;
        bit err;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   accept_cyc = 0;

    // Drive one request, wait (bounded) for acceptance, push its expectation.
    task automatic send(input exp_t e, input bit hold);
        bit got = 1'b0;
        @(negedge clk);
        angle      = e.ang;
        hypotenuse = e.hyp;
        in_valid   = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            if (in_ready) begin
                @(posedge clk);
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        accept_cyc = cyc;
        if (!hold) in_valid = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL accept ang=%0d hyp=%0d: in_ready never seen, required 1", e.ang, e.hyp);
        end
        sb.push_back(e);
    endtask

    // Wait (bounded) for out_valid; sample outputs and latency. No handshake.
    task automatic wait_result(output int oa, output int ob, output int oc,
                               output bit oe, output int lat, output bit ok);
        ok = 1'b0; oa = 0; ob = 0; oc = 0; oe = 1'b0; lat = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (out_valid) begin
                oa  = a;
                ob  = b;
                oc  = c;
                oe  = out_err;
                lat = cyc - accept_cyc;
                ok  = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || a !== '0 || b !== '0 ||
            c !== '0 || out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b a=%0d b=%0d c=%0d err=%b, required 0 0 0 0 0 0",
                     in_ready, out_valid, a, b, c, out_err);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        exp_t tab[$];
        exp_t e;
        int   oa, ob, oc, lat;
        bit   oe, ok;
        int   L = ITER + 2;
        tab = '{
            '{45,   10,  7,    7,    10,  1'b0, L},
            '{30,   20,  17,   10,   20,  1'b0, L},
            '{50,   30,  19,   B50,  30,  1'b0, L},
            '{135,  100, -71,  B135, 100, 1'b0, L},
            '{-150, 50,  A150, -25,  50,  1'b0, L},
            '{180,  10,  -10,  0,    10,  1'b0, L},
            '{-180, 10,  -10,  0,    10,  1'b0, L},
            '{90,   40,  0,    40,   40,  1'b0, L},
            '{-90,  10,  0,    -10,  10,  1'b0, L},
            '{60,   0,   0,    0,    0,   1'b0, L},
            '{200,  10,  0,    0,    0,   1'b1, 2},
            '{-181, 10,  0,    0,    0,   1'b1, 2},
            '{0,    -1,  0,    0,    0,   1'b1, 2}
        };
        foreach (tab[k]) begin
            send(tab[k], 1'b0);
            wait_result(oa, ob, oc, oe, lat, ok);
            e = sb.pop_front();
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL timeout ang=%0d hyp=%0d: out_valid never rose", e.ang, e.hyp);
            end else begin
                if (oa > e.a + 1 || oa < e.a - 1) begin
                    miscompares++;
                    $display("FAIL a ang=%0d hyp=%0d: got %0d, required %0d+-1", e.ang, e.hyp, oa, e.a);
                end
                vectors++;
                if (ob > e.b + 1 || ob < e.b - 1) begin
                    miscompares++;
                    $display("FAIL b ang=%0d hyp=%0d: got %0d, required %0d+-1", e.ang, e.hyp, ob, e.b);
                end
                vectors++;
                if (oc !== e.c || oe !== e.err) begin
                    miscompares++;
                    $display("FAIL c_err ang=%0d hyp=%0d: got c=%0d err=%b, required c=%0d err=%b",
                             e.ang, e.hyp, oc, oe, e.c, e.err);
                end
                vectors++;
                if (lat !== e.lat) begin
                    miscompares++;
                    $display("FAIL latency ang=%0d hyp=%0d: got %0d edges, required %0d", e.ang, e.hyp, lat, e.lat);
                end
            end
            consume();
        end
    endtask

    task automatic test_handshake();
        exp_t e;
        int   oa, ob, oc, lat;
        bit   oe, ok;
        // out_ready without out_valid must do nothing
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_out_ready: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        send('{45, 10, 7, 7, 10, 1'b0, ITER + 2}, 1'b0);
        wait_result(oa, ob, oc, oe, lat, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || oa > e.a + 1 || oa < e.a - 1 || ob > e.b + 1 || ob < e.b - 1 || oc !== e.c) begin
            miscompares++;
            $display("FAIL hs_result: ok=%b a=%0d b=%0d c=%0d, required a=%0d b=%0d c=%0d",
                     ok, oa, ob, oc, e.a, e.b, e.c);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || a !== oa || b !== ob || c !== oc) begin
                miscompares++;
                $display("FAIL hs_hold cycle %0d: out_valid=%b in_ready=%b a=%0d b=%0d c=%0d, required 1 0 %0d %0d %0d",
                         i, out_valid, in_ready, a, b, c, oa, ob, oc);
            end
        end
        consume();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hs_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   oa, ob, oc, lat;
        bit   oe, ok;
        send('{10, 100, 98, 17, 100, 1'b0, ITER + 2}, 1'b0);
        // accept edge already passed: 1 PREP edge + 5 rotations -> iteration 5
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        vectors++;
        if (out_valid !== 1'b0 || a !== '0 || b !== '0 || c !== '0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: out_valid=%b a=%0d b=%0d c=%0d in_ready=%b, required 0 0 0 0 0",
                     out_valid, a, b, c, in_ready);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (ITER + 4) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_stale: out_valid=%b after abort, required 0", out_valid);
        end
        send('{0, 64, 64, 0, 64, 1'b0, ITER + 2}, 1'b0);
        wait_result(oa, ob, oc, oe, lat, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || oa > e.a + 1 || oa < e.a - 1 || ob > e.b + 1 || ob < e.b - 1 ||
            oc !== e.c || oe !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset: ok=%b a=%0d b=%0d c=%0d err=%b, required a=%0d b=%0d c=%0d err=0",
                     ok, oa, ob, oc, oe, e.a, e.b, e.c);
        end
        consume();
    endtask

    task automatic test_busy_drop();
        exp_t e;
        int   oa, ob, oc, lat;
        bit   oe, ok;
        int   ready_seen = 0;
        int   extra = 0;
        send('{30, 20, 17, 10, 20, 1'b0, ITER + 2}, 1'b1);
        for (int i = 0; i < 200 && !out_valid; i++) begin
            if (in_ready) ready_seen++;
            @(negedge clk);
        end
        wait_result(oa, ob, oc, oe, lat, ok);
        e = sb.pop_front();
        vectors++;
        if (ready_seen !== 0) begin
            miscompares++;
            $display("FAIL busy_ready: in_ready high %0d cycles while busy, required 0", ready_seen);
        end
        vectors++;
        if (!ok || oa > e.a + 1 || oa < e.a - 1 || ob > e.b + 1 || ob < e.b - 1 || oc !== e.c) begin
            miscompares++;
            $display("FAIL busy_result: ok=%b a=%0d b=%0d c=%0d, required a=%0d b=%0d c=%0d",
                     ok, oa, ob, oc, e.a, e.b, e.c);
        end
        consume();
        in_valid = 1'b0;
        for (int i = 0; i < ITER + 8; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL busy_extra: %0d cycles of unexpected out_valid, required 0", extra);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_vectors();
        test_handshake();
        test_reset_mid();
        test_busy_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
